vga_sprite_painter: RTL and testbench
=====================================

// Module: vga_sprite_painter
// PURPOSE
//  Pixel-colour stage directly downstream of the VGA timing generator. Consumes
//  hcount/vcount/vid/hs/vs, draws one bordered square sprite over a flat
//  background, and emits 12-bit RGB plus re-aligned syncs to the pins. The
//  sprite position arrives over a valid/ready port and commits only at frame
//  boundaries, so no tearing occurs.
// PARAMETERS
//  H_ACTIVE   640     visible pixels per line
//  V_ACTIVE   480     visible lines per frame
//  SPR_SIZE   16      sprite edge length in pixels (>=3)
//  BG_COLOR   12'h000 background RGB444
//  FILL_COLOR 12'hF00 sprite interior RGB444
//  EDGE_COLOR 12'hFFF sprite 1-pixel border RGB444
// PORTS
//  clk        in  1   pixel-domain clock
//  reset      in  1   asynchronous, active-high
//  enable     in  1   pixel tick; the same strobe that drives the timing generator
//  hcount     in  10  horizontal counter from timing generator
//  vcount     in  10  vertical counter from timing generator
//  vid        in  1   active-video flag; describes hcount/vcount of previous tick
//  hs, vs     in  1   active-low syncs; same one-tick lag as vid
//  pos_valid  in  1   new sprite position offered
//  pos_ready  out 1   block can accept a position
//  pos_x      in  10  requested sprite left edge
//  pos_y      in  10  requested sprite top edge
//  rgb        out 12  pixel colour {R,G,B} 4 bits each
//  hs_o, vs_o out 1   syncs aligned with rgb
//  frame_start out 1  one-clk pulse when a new frame's position commits
// BEHAVIOUR
//  - Reset: rgb=0, hs_o=1, vs_o=1, pos_ready=1, frame_start=0, active pos=(0,0),
//    pending register empty. Reset mid-frame drops any pending position.
//  - All pipeline regs advance only when enable=1; when enable=0 they hold.
//    frame_start is low on every cycle except the commit cycle.
//  - Stage 1: register hcount/vcount (x_d,y_d) so they align with vid/hs/vs.
//    Stage 2: compute hit from (x_d,y_d) and the active position, register rgb,
//    hs_o, vs_o. Latency: 2 enable ticks from vid/hs/vs input to rgb/hs_o/vs_o.
//  - Colour: if delayed vid=0 -> rgb=0 (blanking, mandatory). Else if
//    px<=x_d<=px+SPR_SIZE-1 and py<=y_d<=py+SPR_SIZE-1: EDGE_COLOR when x_d or
//    y_d is on the first/last row/column, else FILL_COLOR. Otherwise BG_COLOR.
//    Comparisons in 11-bit unsigned to avoid wrap.
//  - Handshake: pos_ready = !pending_full. Transfer when pos_valid&&pos_ready on
//    any clk edge (independent of enable). Captured values clamped:
//    x=min(pos_x,H_ACTIVE-SPR_SIZE), y=min(pos_y,V_ACTIVE-SPR_SIZE).
//  - Commit: on an enable tick where input vs goes 1->0 (registered previous vs),
//    if pending_full: active<=pending, pending_full<=0, frame_start=1 for that
//    clk. If no pending, frame_start stays 0 and active holds.
//  - Simultaneous commit and pos_valid: pos_ready was 0 that cycle, so no
//    accept; pos_ready rises the next cycle. Never more than one pending entry.
//  - Position never changes mid-frame; a value accepted during vsync waits for
//    the next vs falling edge.
// TESTING
//  1 Assert reset mid-line with enable toggling -> rgb=0,hs_o=1,vs_o=1,
//    pos_ready=1, frame_start=0 immediately (async).
//  2 Commit pos (100,50), run a frame -> pixel (100,50)=12'hFFF, (108,58)=12'hF00,
//    (116,50)=12'h000, (115,65)=12'hFFF; rgb lags vid by exactly 2 enable ticks.
//  3 Offer (200,200) at line 100 -> pos_ready drops next clk; sprite stays at old
//    pos rest of frame; moves after vs falls with one frame_start pulse.
//  4 Hold pos_valid with second value while pending full -> not accepted until
//    clk after commit; then commits on following frame.
//  5 Offer (700,475) -> committed position (624,464); sprite fully on-screen.
//  6 Sprite at (624,0): hcount 640..799 -> rgb=0; hs_o low for exactly 96 ticks
//    matching input hs shifted by 2 enable ticks; enable=0 freezes all outputs.

Source files
------------

// File: rtl/vga_sprite_painter.sv
// Pixel-colour stage behind the VGA timing generator: one bordered square sprite
// over a flat background, with the sprite position committed only at vsync falling edges.
module vga_sprite_painter #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned SPR_SIZE   = 16,
    parameter logic [11:0] BG_COLOR   = 12'h000,
    parameter logic [11:0] FILL_COLOR = 12'hF00,
    parameter logic [11:0] EDGE_COLOR = 12'hFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [9:0]  hcount,
    input  logic [9:0]  vcount,
    input  logic        vid,
    input  logic        hs,
    input  logic        vs,
    input  logic        pos_valid,
    output logic        pos_ready,
    input  logic [9:0]  pos_x,
    input  logic [9:0]  pos_y,
    output logic [11:0] rgb,
    output logic        hs_o,
    output logic        vs_o,
    output logic        frame_start
);

    localparam logic [9:0]  X_MAX = 10'(H_ACTIVE - SPR_SIZE);
    localparam logic [9:0]  Y_MAX = 10'(V_ACTIVE - SPR_SIZE);
    localparam logic [10:0] SPAN  = 11'(SPR_SIZE - 1);

    typedef enum logic {
        PEND_EMPTY,
        PEND_FULL
    } pend_state_e;

    pend_state_e pend_state_q, pend_state_d;

    logic [9:0]  hc_q, hc_d, vc_q, vc_d;
    logic [9:0]  x_q, x_d, y_q, y_d;
    logic        vid_q, vid_d, hs_q, hs_d, vs_q, vs_d;
    logic [11:0] rgb_q, rgb_d;
    logic        hs_o_q, hs_o_d, vs_o_q, vs_o_d;
    logic [9:0]  act_x_q, act_x_d, act_y_q, act_y_d;
    logic [9:0]  pend_x_q, pend_x_d, pend_y_q, pend_y_d;
    logic        frame_start_q, frame_start_d;

    logic        accept, commit;
    logic [10:0] xe, ye, pxe, pye;
    logic        in_x, in_y, on_edge;
    logic [11:0] pix_color;

    // vs_q is the previous-tick vs, so this is the falling edge of the input sync
    assign commit = enable && vs_q && !vs && (pend_state_q == PEND_FULL);
    assign accept = pos_valid && pos_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_state_q <= PEND_EMPTY;
        end else begin
            pend_state_q <= pend_state_d;
        end
    end

    always_comb begin
        pend_state_d = pend_state_q;
        case (pend_state_q)
            PEND_EMPTY: if (pos_valid) pend_state_d = PEND_FULL;
            PEND_FULL:  if (commit)    pend_state_d = PEND_EMPTY;
            default:                   pend_state_d = PEND_EMPTY;
        endcase
    end

    always_comb begin
        pos_ready = (pend_state_q == PEND_EMPTY);
    end

    always_comb begin
        xe  = {1'b0, x_q};
        ye  = {1'b0, y_q};
        pxe = {1'b0, act_x_q};
        pye = {1'b0, act_y_q};
        in_x = (xe >= pxe) && (xe <= pxe + SPAN);
        in_y = (ye >= pye) && (ye <= pye + SPAN);
        on_edge = (xe == pxe) || (xe == pxe + SPAN) || (ye == pye) || (ye == pye + SPAN);
        if (!vid_q) begin
            pix_color = '0;
        end else if (in_x && in_y) begin
            pix_color = on_edge ? EDGE_COLOR : FILL_COLOR;
        end else begin
            pix_color = BG_COLOR;
        end
    end

    always_comb begin
        hc_d   = hc_q;
        vc_d   = vc_q;
        x_d    = x_q;
        y_d    = y_q;
        vid_d  = vid_q;
        hs_d   = hs_q;
        vs_d   = vs_q;
        rgb_d  = rgb_q;
        hs_o_d = hs_o_q;
        vs_o_d = vs_o_q;
        if (enable) begin
            hc_d   = hcount;
            vc_d   = vcount;
            x_d    = hc_q;
            y_d    = vc_q;
            vid_d  = vid;
            hs_d   = hs;
            vs_d   = vs;
            rgb_d  = pix_color;
            hs_o_d = hs_q;
            vs_o_d = vs_q;
        end
    end

    always_comb begin
        act_x_d       = act_x_q;
        act_y_d       = act_y_q;
        pend_x_d      = pend_x_q;
        pend_y_d      = pend_y_q;
        frame_start_d = commit;
        if (commit) begin
            act_x_d = pend_x_q;
            act_y_d = pend_y_q;
        end
        if (accept) begin
            pend_x_d = (pos_x > X_MAX) ? X_MAX : pos_x;
            pend_y_d = (pos_y > Y_MAX) ? Y_MAX : pos_y;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hc_q          <= '0;
            vc_q          <= '0;
            x_q           <= '0;
            y_q           <= '0;
            vid_q         <= 1'b0;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            rgb_q         <= '0;
            hs_o_q        <= 1'b1;
            vs_o_q        <= 1'b1;
            act_x_q       <= '0;
            act_y_q       <= '0;
            pend_x_q      <= '0;
            pend_y_q      <= '0;
            frame_start_q <= 1'b0;
        end else begin
            hc_q          <= hc_d;
            vc_q          <= vc_d;
            x_q           <= x_d;
            y_q           <= y_d;
            vid_q         <= vid_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            rgb_q         <= rgb_d;
            hs_o_q        <= hs_o_d;
            vs_o_q        <= vs_o_d;
            act_x_q       <= act_x_d;
            act_y_q       <= act_y_d;
            pend_x_q      <= pend_x_d;
            pend_y_q      <= pend_y_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign rgb         = rgb_q;
    assign hs_o        = hs_o_q;
    assign vs_o        = vs_o_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sprite_painter.sv
// Directed bench for vga_sprite_painter: drives a VGA-style counter sequence,
// models expected pixels in a scoreboard queue and checks every tick.
module tb_vga_sprite_painter;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [9:0]  hcount, vcount;
    logic        vid, hs, vs;
    logic        pos_valid, pos_ready;
    logic [9:0]  pos_x, pos_y;
    logic [11:0] rgb;
    logic        hs_o, vs_o, frame_start;

    vga_sprite_painter #(
        .H_ACTIVE  (640),
        .V_ACTIVE  (480),
        .SPR_SIZE  (16),
        .BG_COLOR  (12'h000),
        .FILL_COLOR(12'hF00),
        .EDGE_COLOR(12'hFFF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .hcount     (hcount),
        .vcount     (vcount),
        .vid        (vid),
        .hs         (hs),
        .vs         (vs),
        .pos_valid  (pos_valid),
        .pos_ready  (pos_ready),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .rgb        (rgb),
        .hs_o       (hs_o),
        .vs_o       (vs_o),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
        int          x;
        int          y;
        logic        vid;
    } ent_t;

    typedef struct {
        int          x;
        int          y;
        logic [11:0] c;
    } prb_t;

    ent_t sbq[$];
    ent_t last;
    prb_t pq[$];

    int checks = 0;
    int errors = 0;

    int gh, gv, ph, pv;
    int m_px, m_py, m_pend_x, m_pend_y;
    bit m_full, m_fs, m_vs_prev;
    bit off_valid;
    int off_x, off_y;
    int hs_low, fs_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] ref_color(int x, int y, logic v, int px, int py);
        if (!v) return 12'h000;
        if (x >= px && x <= px + 15 && y >= py && y <= py + 15) begin
            if (x == px || x == px + 15 || y == py || y == py + 15) return 12'hFFF;
            return 12'hF00;
        end
        return 12'h000;
    endfunction

    task automatic model_reset();
        m_px = 0; m_py = 0; m_pend_x = 0; m_pend_y = 0;
        m_full = 0; m_fs = 0; m_vs_prev = 1;
        off_valid = 0;
        pos_valid = 1'b0;
        sbq.delete();
        last = '{rgb: 12'h000, hs: 1'b1, vs: 1'b1, x: -1, y: -1, vid: 1'b0};
        sbq.push_back(last);
        ph = 799;
    endtask

    task automatic offer(input int x, input int y);
        off_valid = 1; off_x = x; off_y = y;
    endtask

    task automatic add_probe(input int x, input int y, input logic [11:0] c);
        prb_t p;
        p.x = x; p.y = y; p.c = c;
        pq.push_back(p);
    endtask

    task automatic tick(input bit en);
        bit   acc, com;
        ent_t e;
        enable    = en;
        hcount    = 10'(gh);
        vcount    = 10'(gv);
        vid       = (ph < 640) && (pv < 480);
        hs        = !(ph >= 656 && ph < 752);
        vs        = !(pv == 490 || pv == 491);
        pos_valid = off_valid;
        pos_x     = 10'(off_x);
        pos_y     = 10'(off_y);
        acc = off_valid && !m_full;
        com = en && m_vs_prev && !vs && m_full;
        if (en) begin
            e.rgb = ref_color(ph, pv, vid, m_px, m_py);
            e.hs = hs; e.vs = vs; e.x = ph; e.y = pv; e.vid = vid;
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        m_fs = 0;
        if (com) begin
            m_px = m_pend_x; m_py = m_pend_y; m_full = 0; m_fs = 1;
        end else if (acc) begin
            m_pend_x = (off_x > 624) ? 624 : off_x;
            m_pend_y = (off_y > 464) ? 464 : off_y;
            m_full = 1;
        end
        if (acc) off_valid = 0;
        if (en) begin
            m_vs_prev = vs;
            ph = gh; pv = gv;
            if (sbq.size() == 2) begin
                last = sbq.pop_front();
                foreach (pq[i])
                    if (last.vid && pq[i].x == last.x && pq[i].y == last.y)
                        chk("probe_pixel", 32'(rgb), 32'(pq[i].c));
            end
        end
        chk("rgb", 32'(rgb), 32'(last.rgb));
        chk("hs_o", 32'(hs_o), 32'(last.hs));
        chk("vs_o", 32'(vs_o), 32'(last.vs));
        chk("pos_ready", 32'(pos_ready), 32'(!m_full));
        chk("frame_start", 32'(frame_start), 32'(m_fs));
        if (en && hs_o === 1'b0) hs_low++;
        if (frame_start === 1'b1) fs_cnt++;
    endtask

    task automatic run_line(input int v, input bit frz);
        hs_low = 0;
        gv = v;
        for (int h = 0; h < 800; h++) begin
            gh = h;
            if (frz && (h % 7 == 3)) tick(1'b0);
            tick(1'b1);
        end
        chk("hs_low_ticks", 32'(hs_low), 32'd96);
    endtask

    task automatic vblank(input int exp_pulses);
        fs_cnt = 0;
        run_line(480, 1'b0);
        run_line(490, 1'b0);
        run_line(491, 1'b0);
        run_line(492, 1'b0);
        chk("frame_start_pulses", 32'(fs_cnt), 32'(exp_pulses));
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; hcount = '0; vcount = '0;
        vid = 1'b0; hs = 1'b1; vs = 1'b1; pos_x = '0; pos_y = '0;
        gh = 0; gv = 0; pv = 524;
        model_reset();
        #2;
        chk("reset_rgb", 32'(rgb), 32'h0);
        chk("reset_hs_o", 32'(hs_o), 32'd1);
        chk("reset_vs_o", 32'(vs_o), 32'd1);
        chk("reset_pos_ready", 32'(pos_ready), 32'd1);
        chk("reset_frame_start", 32'(frame_start), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // First commit and probe pixels of the (100,50) sprite
        offer(100, 50);
        vblank(1);
        add_probe(100, 50, 12'hFFF);
        add_probe(108, 58, 12'hF00);
        add_probe(116, 50, 12'h000);
        add_probe(115, 65, 12'hFFF);
        run_line(49, 1'b0);
        run_line(50, 1'b0);
        run_line(58, 1'b0);
        run_line(65, 1'b0);
        run_line(66, 1'b0);

        // Mid-frame offer waits for the next vsync edge
        pq.delete();
        add_probe(100, 50, 12'hFFF);
        add_probe(108, 58, 12'hF00);
        offer(200, 200);
        run_line(100, 1'b0);
        run_line(58, 1'b0);
        run_line(50, 1'b0);
        vblank(1);
        pq.delete();
        add_probe(200, 200, 12'hFFF);
        add_probe(208, 208, 12'hF00);
        add_probe(108, 58, 12'h000);
        run_line(200, 1'b0);
        run_line(208, 1'b0);
        run_line(58, 1'b0);

        // Second offer held while pending is full
        offer(300, 100);
        run_line(201, 1'b0);
        offer(50, 300);
        run_line(202, 1'b0);
        chk("held_not_ready", 32'(pos_ready), 32'd0);
        vblank(1);
        chk("second_accepted", 32'(pos_ready), 32'd0);
        pq.delete();
        add_probe(300, 100, 12'hFFF);
        add_probe(315, 115, 12'hFFF);
        add_probe(301, 101, 12'hF00);
        run_line(100, 1'b0);
        run_line(115, 1'b0);
        vblank(1);
        pq.delete();
        add_probe(50, 300, 12'hFFF);
        add_probe(66, 300, 12'h000);
        add_probe(49, 300, 12'h000);
        run_line(300, 1'b0);

        // Clamped request
        offer(700, 475);
        vblank(1);
        pq.delete();
        add_probe(624, 464, 12'hFFF);
        add_probe(623, 464, 12'h000);
        add_probe(639, 470, 12'hFFF);
        add_probe(630, 470, 12'hF00);
        add_probe(630, 479, 12'hFFF);
        run_line(464, 1'b0);
        run_line(470, 1'b0);
        run_line(479, 1'b0);

        // Right-edge sprite, blanking tail, and enable freeze
        offer(624, 0);
        vblank(1);
        pq.delete();
        add_probe(624, 0, 12'hFFF);
        add_probe(639, 0, 12'hFFF);
        add_probe(630, 1, 12'hF00);
        run_line(0, 1'b0);
        run_line(1, 1'b1);

        // Asynchronous reset mid-line with a pending entry and sprite pixels on screen
        offer(10, 10);
        gv = 2;
        for (int h = 0; h < 632; h++) begin
            gh = h;
            tick(1'b0);
            tick(1'b1);
        end
        chk("pre_reset_pending", 32'(pos_ready), 32'd0);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rgb", 32'(rgb), 32'h0);
        chk("async_hs_o", 32'(hs_o), 32'd1);
        chk("async_vs_o", 32'(vs_o), 32'd1);
        chk("async_pos_ready", 32'(pos_ready), 32'd1);
        chk("async_frame_start", 32'(frame_start), 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;

        pq.delete();
        add_probe(0, 3, 12'hFFF);
        add_probe(5, 3, 12'hF00);
        add_probe(20, 3, 12'h000);
        run_line(3, 1'b0);
        vblank(0);
        run_line(3, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
